// File: rtl/fetch_sequencer_pkg.sv
// Shared types and defaults for the fetch sequencer.
// Sequencer states, address/offset widths and the reset PC.
package fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        REQ    = 2'b00,
        VALID  = 2'b01,
        HALTED = 2'b10
    } seqState_t;

    localparam int ADDR_W_DEF   = 16;
    localparam int OFFSET_W_DEF = 12;
    localparam int INSTR_W      = 16;

    localparam logic [ADDR_W_DEF-1:0] RESET_PC_DEF = '0;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory req/ack bus between the fetch sequencer and memory.
// The master issues requests; the slave returns data with the ack.
interface fetch_sequencer_if
    import fetch_sequencer_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
);

    logic               ImemReq;
    logic [ADDR_W-1:0]  ImemAddr;
    logic               ImemAck;
    logic [INSTR_W-1:0] ImemData;

    modport master (
        output ImemReq,
        output ImemAddr,
        input  ImemAck,
        input  ImemData
    );

    modport slave (
        input  ImemReq,
        input  ImemAddr,
        output ImemAck,
        output ImemData
    );

endinterface

// File: rtl/fetch_sequencer_next_pc_sel.sv
// Next-PC priority mux: absolute jump, then signed branch, then increment.
// All arithmetic wraps modulo 2^ADDR_W.
module fetch_sequencer_next_pc_sel
    import fetch_sequencer_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int OFFSET_W = OFFSET_W_DEF
) (
    input  logic [ADDR_W-1:0]   InstrPC,
    input  logic                Jump,
    input  logic [ADDR_W-1:0]   JumpTarget,
    input  logic                DoBranch,
    input  logic [OFFSET_W-1:0] BranchOffset,
    output logic [ADDR_W-1:0]   NextPc
);

    logic [ADDR_W-1:0] offsetExt;

    assign offsetExt = ADDR_W'($signed(BranchOffset));

    always_comb begin
        NextPc = InstrPC + ADDR_W'(1);
        if (Jump) begin
            NextPc = JumpTarget;
        end else if (DoBranch) begin
            NextPc = InstrPC + offsetExt;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// PC and instruction-fetch stage: fetches over a req/ack bus, holds the
// instruction until retired, then redirects the PC or halts.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                OFFSET_W = OFFSET_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic                Clk,
    input  logic                Reset_n,
    fetch_sequencer_if.master   imem,
    output logic                InstrValid,
    output logic [INSTR_W-1:0]  Instr,
    output logic [ADDR_W-1:0]   InstrPC,
    input  logic                Advance,
    input  logic                DoBranch,
    input  logic [OFFSET_W-1:0] BranchOffset,
    input  logic                Jump,
    input  logic [ADDR_W-1:0]   JumpTarget,
    input  logic                Halt,
    output logic                Halted,
    output logic [15:0]         RetireCount
);

    seqState_t          state;
    seqState_t          stateNext;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pcNext;
    logic [ADDR_W-1:0]  selPc;
    logic [ADDR_W-1:0]  instrPc;
    logic [ADDR_W-1:0]  instrPcNext;
    logic [INSTR_W-1:0] instr;
    logic [INSTR_W-1:0] instrNext;
    logic [15:0]        retireCnt;
    logic [15:0]        retireCntNext;

    fetch_sequencer_next_pc_sel #(
        .ADDR_W   (ADDR_W),
        .OFFSET_W (OFFSET_W)
    ) uNextPc (
        .InstrPC      (instrPc),
        .Jump         (Jump),
        .JumpTarget   (JumpTarget),
        .DoBranch     (DoBranch),
        .BranchOffset (BranchOffset),
        .NextPc       (selPc)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= REQ;
            pc        <= RESET_PC;
            instr     <= '0;
            instrPc   <= '0;
            retireCnt <= '0;
        end else begin
            state     <= stateNext;
            pc        <= pcNext;
            instr     <= instrNext;
            instrPc   <= instrPcNext;
            retireCnt <= retireCntNext;
        end
    end

    always_comb begin
        stateNext     = state;
        pcNext        = pc;
        instrNext     = instr;
        instrPcNext   = instrPc;
        retireCntNext = retireCnt;
        unique case (state)
            REQ: begin
                if (imem.ImemAck) begin
                    instrNext   = imem.ImemData;
                    instrPcNext = pc;
                    stateNext   = VALID;
                end
            end
            VALID: begin
                if (Advance) begin
                    retireCntNext = retireCnt + 16'd1;
                    // A halting retire keeps the PC where it was.
                    if (Halt) begin
                        stateNext = HALTED;
                    end else begin
                        pcNext    = selPc;
                        stateNext = REQ;
                    end
                end
            end
            HALTED: begin
                stateNext = HALTED;
            end
            default: begin
                stateNext = REQ;
            end
        endcase
    end

    // Gated by reset so the request drops as soon as reset asserts.
    assign imem.ImemReq  = (state == REQ) && Reset_n;
    assign imem.ImemAddr = pc;

    assign InstrValid  = (state == VALID);
    assign Halted      = (state == HALTED);
    assign Instr       = instr;
    assign InstrPC     = instrPc;
    assign RetireCount = retireCnt;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: stimulus queues expected fetch
// addresses and instructions, a negedge monitor pops and compares them.
module tb_fetch_sequencer;
    import fetch_sequencer_pkg::*;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc;
        logic [15:0] cnt;
    } instrExp_t;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        InstrValid;
    logic [15:0] Instr;
    logic [15:0] InstrPC;
    logic        Advance = 1'b0;
    logic        DoBranch = 1'b0;
    logic [11:0] BranchOffset = '0;
    logic        Jump = 1'b0;
    logic [15:0] JumpTarget = '0;
    logic        Halt = 1'b0;
    logic        Halted;
    logic [15:0] RetireCount;

    fetch_sequencer_if #(.ADDR_W(16)) imem ();

    fetch_sequencer dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .imem         (imem),
        .InstrValid   (InstrValid),
        .Instr        (Instr),
        .InstrPC      (InstrPC),
        .Advance      (Advance),
        .DoBranch     (DoBranch),
        .BranchOffset (BranchOffset),
        .Jump         (Jump),
        .JumpTarget   (JumpTarget),
        .Halt         (Halt),
        .Halted       (Halted),
        .RetireCount  (RetireCount)
    );

    always #5 Clk = ~Clk;

    int          nChecks = 0;
    int          nFail = 0;
    logic [15:0] expAddrQ[$];
    instrExp_t   expInstrQ[$];
    logic [15:0] expCount = '0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeoutFail(input string name);
        nChecks++;
        nFail++;
        $display("FAIL %s: timeout waiting on DUT", name);
    endtask

    logic        prevReq = 1'b0;
    logic        prevValid = 1'b0;
    logic [15:0] reqAddr = '0;

    always @(negedge Clk) begin
        instrExp_t e;
        if (imem.ImemReq && !prevReq) begin
            if (expAddrQ.size() == 0) begin
                timeoutFail("unexpectedReq");
            end else begin
                check("reqAddr", imem.ImemAddr, expAddrQ.pop_front());
            end
            reqAddr = imem.ImemAddr;
        end else if (imem.ImemReq) begin
            check("addrStable", imem.ImemAddr, reqAddr);
        end
        if (InstrValid && !prevValid) begin
            if (expInstrQ.size() == 0) begin
                timeoutFail("unexpectedValid");
            end else begin
                e = expInstrQ.pop_front();
                check("instr", Instr, e.instr);
                check("instrPc", InstrPC, e.pc);
                check("countAtValid", RetireCount, e.cnt);
            end
        end
        prevReq   = imem.ImemReq;
        prevValid = InstrValid;
    end

    task automatic fetch(input logic [15:0] data, input logic [15:0] pc,
                         input int stall);
        int n = 0;
        while (!imem.ImemReq && n < 50) begin
            @(posedge Clk); #1;
            n++;
        end
        if (!imem.ImemReq) begin
            timeoutFail("fetchWait");
            return;
        end
        repeat (stall) begin
            @(posedge Clk); #1;
        end
        expInstrQ.push_back('{instr: data, pc: pc, cnt: expCount});
        imem.ImemAck  = 1'b1;
        imem.ImemData = data;
        @(posedge Clk); #1;
        imem.ImemAck  = 1'b0;
        imem.ImemData = '0;
        check("ackToValid", InstrValid, 1);
    endtask

    task automatic retire(input logic j, input logic [15:0] tgt,
                          input logic br, input logic [11:0] off,
                          input logic h, input logic [15:0] expNext);
        int n = 0;
        while (!InstrValid && n < 50) begin
            @(posedge Clk); #1;
            n++;
        end
        if (!InstrValid) begin
            timeoutFail("retireWait");
            return;
        end
        Advance      = 1'b1;
        Jump         = j;
        JumpTarget   = tgt;
        DoBranch     = br;
        BranchOffset = off;
        Halt         = h;
        if (!h) expAddrQ.push_back(expNext);
        expCount++;
        @(posedge Clk); #1;
        Advance  = 1'b0;
        Jump     = 1'b0;
        DoBranch = 1'b0;
        Halt     = 1'b0;
        check("retireCount", RetireCount, expCount);
        if (!h) check("advToReq", imem.ImemReq, 1);
        else    check("halted", Halted, 1);
    endtask

    initial begin
        imem.ImemAck  = 1'b0;
        imem.ImemData = '0;

        repeat (2) @(posedge Clk);
        #1;
        check("rstReq", imem.ImemReq, 0);
        check("rstValid", InstrValid, 0);
        check("rstHalted", Halted, 0);
        check("rstCount", RetireCount, 0);
        check("rstInstr", Instr, 0);
        check("rstInstrPc", InstrPC, 0);
        expAddrQ.push_back(16'h0000);
        Reset_n = 1'b1;

        fetch(16'h1234, 16'h0000, 0);
        retire(0, 16'h0000, 0, 12'h000, 0, 16'h0001);
        fetch(16'h1111, 16'h0001, 0);
        retire(1, 16'h0010, 0, 12'h000, 0, 16'h0010);
        fetch(16'h2222, 16'h0010, 1);
        retire(0, 16'h0000, 1, 12'hFFC, 0, 16'h000C);
        fetch(16'h3333, 16'h000C, 0);
        retire(1, 16'h0010, 0, 12'h000, 0, 16'h0010);
        fetch(16'h4444, 16'h0010, 0);
        retire(0, 16'h0000, 1, 12'h005, 0, 16'h0015);
        fetch(16'h5555, 16'h0015, 0);
        retire(1, 16'hFFFF, 0, 12'h000, 0, 16'hFFFF);
        fetch(16'h6666, 16'hFFFF, 0);
        retire(0, 16'h0000, 0, 12'h000, 0, 16'h0000);
        fetch(16'h7777, 16'h0000, 0);
        retire(1, 16'h0001, 0, 12'h000, 0, 16'h0001);
        fetch(16'h8888, 16'h0001, 0);
        retire(0, 16'h0000, 1, 12'hFFD, 0, 16'hFFFE);

        // Retire controls asserted while still requesting must be ignored.
        Advance    = 1'b1;
        Jump       = 1'b1;
        JumpTarget = 16'h0777;
        repeat (3) begin
            @(posedge Clk); #1;
        end
        check("reqIgnoreCount", RetireCount, expCount);
        check("reqIgnoreAddr", imem.ImemAddr, 16'hFFFE);
        check("reqIgnoreReq", imem.ImemReq, 1);
        Advance = 1'b0;
        Jump    = 1'b0;

        fetch(16'h9999, 16'hFFFE, 5);
        retire(1, 16'h0200, 1, 12'h008, 0, 16'h0200);
        fetch(16'hAAAA, 16'h0200, 0);
        retire(1, 16'h0033, 0, 12'h000, 0, 16'h0033);

        @(posedge Clk); #1;
        Reset_n = 1'b0;
        #1;
        check("midRstReq", imem.ImemReq, 0);
        check("midRstCount", RetireCount, 0);
        expCount = '0;
        expAddrQ.push_back(16'h0000);
        repeat (2) @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        #1;
        check("postRstAddr", imem.ImemAddr, 16'h0000);
        check("postRstCount", RetireCount, 0);

        fetch(16'hABCD, 16'h0000, 0);
        retire(0, 16'h0000, 1, 12'h008, 1, 16'h0000);
        for (int i = 0; i < 20; i++) begin
            imem.ImemAck = 1'(i % 2);
            Advance      = 1'b1;
            @(posedge Clk); #1;
            check("haltReq", imem.ImemReq, 0);
            check("haltCount", RetireCount, 16'h0001);
            check("haltFlag", Halted, 1);
            check("haltInstrPc", InstrPC, 16'h0000);
        end
        imem.ImemAck = 1'b0;
        Advance      = 1'b0;

        @(posedge Clk); #1;
        check("addrQEmpty", expAddrQ.size(), 0);
        check("instrQEmpty", expInstrQ.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nChecks, nFail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Program-counter and instruction-fetch stage.
- Issues word-addressed requests to instruction memory using a req/ack handshake, and holds the fetched instruction until the control unit retires it.
- On retire, it picks the next PC from the branch logic's DoBranch, a signed branch offset, or an absolute jump.
- Also keeps a retired-instruction counter and a halted state.

Parameters:
- ADDR_W, 16, width of PC and instruction-memory address (word addressed).
- OFFSET_W, 12, width of signed two's-complement branch offset.
- RESET_PC, 0, PC loaded on reset.

Ports:
- Clk  input  1  single clock, rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- ImemReq  output  1  fetch request, held until acknowledged.
- ImemAddr  output  ADDR_W  fetch address, equals PC.
- ImemAck  input  1  memory acknowledge; ImemData is valid in the same cycle.
- ImemData  input  16  instruction word.
- InstrValid  output  1  Instr/InstrPC hold a fetched, unretired instruction.
- Instr  output  16  instruction register.
- InstrPC  output  ADDR_W  address of Instr.
- Advance  input  1  control unit retires the current instruction this cycle.
- DoBranch  input  1  branch-taken flag from BLU, sampled with Advance.
- BranchOffset  input  OFFSET_W  signed offset relative to InstrPC.
- Jump  input  1  absolute redirect, sampled with Advance.
- JumpTarget  input  ADDR_W  absolute target.
- Halt  input  1  retired instruction is a halt, sampled with Advance.
- Halted  output  1  sequencer stopped.
- RetireCount  output  16  number of retired instructions.

Behaviour:
- Reset (asynchronous, Reset_n=0):
  - PC=RESET_PC, state=REQ.
  - Instr=0, InstrPC=0, RetireCount=0.
  - InstrValid=0, Halted=0.
  - ImemReq drops to 0 immediately and stays 0 while reset is asserted.
- State REQ:
  - ImemReq=1, ImemAddr=PC, InstrValid=0.
  - ImemAddr is stable until ImemAck.
  - On a cycle with ImemAck=1: Instr<=ImemData, InstrPC<=PC, next state VALID.
  - An ack in the first cycle of the request is legal.
  - Advance, Jump and Halt are ignored in REQ.
- State VALID:
  - ImemReq=0, InstrValid=1; Instr and InstrPC are held.
  - Without Advance: stay in VALID.
  - On Advance=1:
    - RetireCount<=RetireCount+1, wrapping 0xFFFF->0x0000.
    - Next PC, highest priority first:
      - Jump: next PC = JumpTarget.
      - else DoBranch: next PC = InstrPC + sign_extend(BranchOffset).
      - else: next PC = InstrPC + 1.
    - Arithmetic is modulo 2^ADDR_W. 0xFFFF+1 wraps to 0x0000; a negative offset below 0 wraps to the top.
    - If Halt=1: next state HALTED and PC is left unchanged. Otherwise next state REQ.
  - ImemAck outside REQ is ignored.
- State HALTED:
  - ImemReq=0, InstrValid=0, Halted=1.
  - Instr, InstrPC and RetireCount are frozen.
  - Exit only through reset.
- Latency:
  - Ack to InstrValid: 1 cycle.
  - Advance to next ImemReq: 1 cycle.
  - Minimum 2 cycles per instruction (ack in first REQ cycle, Advance in first VALID cycle).
- Simultaneous inputs:
  - Jump and DoBranch together: Jump wins.
  - Halt together with Jump or DoBranch: the retire still counts and the sequencer halts; PC is not updated.
- DoBranch and BranchOffset are don't-care when Advance=0.
- Reset mid-fetch: the outstanding request is abandoned; after reset the fetch restarts at RESET_PC.

Decomposition:
- Shared package:
  - state encoding (REQ=2'b00, VALID=2'b01, HALTED=2'b10);
  - default ADDR_W and OFFSET_W;
  - RESET_PC constant.
- One sub-module is natural: next_pc_sel, a combinational priority mux with sign-extend adder (Jump/DoBranch/increment).
- Counter and FSM stay in the top level.

Test Plan:
- Reset, ack at the first REQ cycle with ImemData=0x1234:
  - ImemAddr=0x0000;
  - next cycle InstrValid=1, Instr=0x1234, InstrPC=0.
  - Then Advance with no branch -> ImemAddr=0x0001 one cycle later, RetireCount=1.
- InstrPC=0x0010, Advance+DoBranch with BranchOffset=0xFFC (-4) -> next ImemAddr=0x000C. With BranchOffset=0x005 -> next ImemAddr=0x0015.
- Wrap:
  - InstrPC=0xFFFF, Advance without branch -> next ImemAddr=0x0000.
  - InstrPC=0x0001, offset -3 -> next ImemAddr=0xFFFE.
- Priority:
  - Advance with Jump=1, JumpTarget=0x0200, DoBranch=1, offset 8 -> next ImemAddr=0x0200.
  - Advance with Halt=1 -> Halted=1, ImemReq stays 0 for 20 cycles, RetireCount frozen.
- Handshake stall:
  - Hold ImemAck=0 for 5 cycles -> ImemReq=1 and ImemAddr stable throughout.
  - Assert Advance during REQ -> ignored: RetireCount unchanged, ImemAddr unchanged.
- Reset_n pulled low mid-REQ at PC=0x0033:
  - ImemReq falls in the same cycle.
  - After release: ImemAddr=0x0000, RetireCount=0.
